ns_rr_arb: RTL and testbench

Round-robin arbiter with a registered one-hot grant and a valid/ready handshake toward its consumer. It sits directly upstream of `ns_1hot2bin`: `gnt_onehot` drives that encoder's `one_hot_code` unchanged, so the encoder only ever sees a legal one-hot or all-zero value. Fairness comes from a mask that rotates past the most recently accepted requester.

---
 rtl/ns_rr_arb.sv | 126 ++++++++++++
 tb/tb_ns_rr_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ns_rr_arb.sv
// rtl/ns_rr_arb.sv - round-robin arbiter with registered one-hot grant and valid/ready handoff
// Optional feature macro: NS_RR_ARB_LOCK_EN (adds lock port to hold priority on the accepted requester)
module ns_rr_arb #(
    parameter int REQ_WIDTH = 8,
    localparam int IDX_W = $clog2(REQ_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQ_WIDTH-1:0] req,
    input  logic                 gnt_ready,
`ifdef NS_RR_ARB_LOCK_EN
    input  logic                 lock,
`endif
    output logic                 gnt_valid,
    output logic [REQ_WIDTH-1:0] gnt_onehot,
    output logic [IDX_W-1:0]     last_idx
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [REQ_WIDTH-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]     last_idx_q, last_idx_d;
    logic [IDX_W-1:0]     acc_idx;
    logic [IDX_W-1:0]     ptr_after_accept;

    // Requests strictly above ptr win first; otherwise wrap to the lowest set bit of r.
    function automatic logic [REQ_WIDTH-1:0] rr_pick(
        input logic [REQ_WIDTH-1:0] r,
        input logic [IDX_W-1:0]     ptr
    );
        logic [REQ_WIDTH-1:0] masked;
        logic [REQ_WIDTH-1:0] src;
        logic [REQ_WIDTH-1:0] res;
        logic                 found;
        masked = '0;
        res    = '0;
        found  = 1'b0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            masked[i] = r[i] && (IDX_W'(i) > ptr);
        end
        src = (|masked) ? masked : r;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (src[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [REQ_WIDTH-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        acc_idx = onehot_idx(gnt_q);
`ifdef NS_RR_ARB_LOCK_EN
        // Parking the pointer one below the winner keeps that requester at top priority.
        if (lock) begin
            ptr_after_accept = (acc_idx == '0) ? IDX_W'(REQ_WIDTH - 1) : acc_idx - IDX_W'(1);
        end else begin
            ptr_after_accept = acc_idx;
        end
`else
        ptr_after_accept = acc_idx;
`endif
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_idx_d = last_idx_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = rr_pick(req, last_idx_q);
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // Without an accept the grant stays frozen regardless of req.
                if (gnt_ready) begin
                    last_idx_d = ptr_after_accept;
                    if (|req) begin
                        gnt_d = rr_pick(req, ptr_after_accept);
                    end else begin
                        gnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            last_idx_q <= IDX_W'(REQ_WIDTH - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_idx_q <= last_idx_d;
        end
    end

    assign gnt_valid  = (state_q == S_GRANT);
    assign gnt_onehot = gnt_q;
    assign last_idx   = last_idx_q;

endmodule

// File: tb/tb_ns_rr_arb.sv
// tb/tb_ns_rr_arb.sv - self-checking bench for ns_rr_arb against a queue-free rotating-priority model
module tb_ns_rr_arb;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] req = '0;
    logic         gnt_ready = 1'b0;
    logic         lock = 1'b0;
    logic         lock_eff;
    logic         gnt_valid;
    logic [W-1:0] gnt_onehot;
    logic [2:0]   last_idx;

    always #5 clk = ~clk;

    ns_rr_arb #(.REQ_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_ready  (gnt_ready),
`ifdef NS_RR_ARB_LOCK_EN
        .lock       (lock),
`endif
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .last_idx   (last_idx)
    );

`ifdef NS_RR_ARB_LOCK_EN
    assign lock_eff = lock;
`else
    assign lock_eff = 1'b0;
`endif

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Walk the priority order last+1, last+2, ... and return the first requester found.
    function automatic int pick(input logic [W-1:0] r, input int last);
        for (int k = 1; k <= W; k++) begin
            if (r[(last + k) % W]) return (last + k) % W;
        end
        return -1;
    endfunction

    logic m_valid;
    int   m_idx;
    int   m_last;

    always @(posedge clk or negedge rst_n) begin : model
        int nl;
        int p;
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_last  <= W - 1;
        end else if (!m_valid) begin
            p = pick(req, m_last);
            if (p >= 0) begin
                m_valid <= 1'b1;
                m_idx   <= p;
            end
        end else if (gnt_ready) begin
            nl = lock_eff ? (m_idx + W - 1) % W : m_idx;
            m_last <= nl;
            p = pick(req, nl);
            if (p >= 0) m_idx <= p;
            else m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("valid", gnt_valid, m_valid);
        chk("onehot", gnt_onehot, m_valid ? (32'd1 << m_idx) : 32'd0);
        chk("last_idx", last_idx, m_last);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        gnt_ready = 1'b0;
        lock = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) step();
        chk("rst_valid", gnt_valid, 0);
        chk("rst_onehot", gnt_onehot, 0);
        chk("rst_last", last_idx, 7);
        rst_n = 1'b1;

        req = 8'hFF;
        gnt_ready = 1'b1;
        step();
        for (int k = 0; k < 9; k++) begin
            chk("ff_seq_gnt", gnt_onehot, 32'd1 << (k % 8));
            chk("ff_seq_last", last_idx, (k == 0) ? 7 : (k - 1) % 8);
            step();
        end

        do_reset();
        req = 8'h90;
        step();
        chk("h90_first", gnt_onehot, 8'h10);
        gnt_ready = 1'b1;
        step();
        chk("h90_second", gnt_onehot, 8'h80);
        chk("h90_last", last_idx, 4);

        do_reset();
        req = 8'h04;
        step();
        chk("hold_first", gnt_onehot, 8'h04);
        req = 8'h01;
        repeat (5) begin
            step();
            chk("hold_frozen", gnt_onehot, 8'h04);
        end
        gnt_ready = 1'b1;
        step();
        chk("hold_next", gnt_onehot, 8'h01);
        chk("hold_last", last_idx, 2);

        do_reset();
        req = 8'h08;
        gnt_ready = 1'b1;
        step();
        chk("pulse_valid", gnt_valid, 1);
        chk("pulse_gnt", gnt_onehot, 8'h08);
        req = '0;
        step();
        chk("pulse_idle_valid", gnt_valid, 0);
        chk("pulse_idle_gnt", gnt_onehot, 0);
        chk("pulse_last", last_idx, 3);
        step();
        chk("pulse_stay_idle", gnt_valid, 0);

        req = 8'hFF;
        gnt_ready = 1'b0;
        step();
        chk("async_pre_valid", gnt_valid, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", gnt_valid, 0);
        chk("async_gnt", gnt_onehot, 0);
        chk("async_last", last_idx, 7);
        step();
        rst_n = 1'b1;
        req = '0;

`ifdef NS_RR_ARB_LOCK_EN
        do_reset();
        req = 8'h06;
        lock = 1'b1;
        gnt_ready = 1'b1;
        repeat (4) begin
            step();
            chk("lock_repeat", gnt_onehot, 8'h02);
        end
        lock = 1'b0;
        step();
        chk("lock_release", gnt_onehot, 8'h04);
`endif

        do_reset();
        repeat (3000) begin
            case ($urandom_range(3))
                0: req = '0;
                1: req = 8'($urandom) & 8'($urandom);
                2: req = 8'(1 << $urandom_range(7));
                default: req = 8'($urandom);
            endcase
            gnt_ready = ($urandom_range(2) != 0);
            lock = $urandom_range(1) == 1;
            rst_n = ($urandom_range(499) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
